// File: rtl/nic_pkg.sv
// Shared definitions for the parametrised NIC: register map, status bit
// positions and a constant clog2 helper usable in parameter expressions.
package nic_pkg;

    // Processor register map
    localparam logic [1:0] ADDR_RXBUF  = 2'b00;
    localparam logic [1:0] ADDR_RXSTAT = 2'b01;
    localparam logic [1:0] ADDR_TXBUF  = 2'b10;
    localparam logic [1:0] ADDR_TXSTAT = 2'b11;

    // Status word layout: bit0 flag, count field starting at bit1, ovf at the MSB
    localparam int STAT_NE_BIT   = 0;
    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_CNT_LSB  = 1;

    // Overflow flag position for a given register width
    function automatic int ovf_bit(input int dw);
        return dw - 1;
    endfunction

    // Ceiling log2, valid for n >= 1
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nic_fifo.sv
// Synchronous FIFO with extra-MSB pointers so full and empty are unambiguous.
// Push is ignored when full and pop is ignored when empty; a push into an empty
// FIFO is not visible at the head until the following cycle.
module nic_fifo
    import nic_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count,
    output logic [W-1:0]            head
);

    localparam int PW = clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array: data only, no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    // Pointer update; reset discards all queued entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/nic_param.sv
// Network interface controller bridging a processor register port to one ring
// router port, with RX/TX FIFOs, occupancy status and a sticky TX overflow flag.
module nic_param
    import nic_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4,
    parameter int VC_BIT   = DATA_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              nicEN,
    input  logic              nicWrEn,
    output logic [DATA_W-1:0] d_out,
    input  logic              net_si,
    output logic              net_ro,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ri,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    localparam int RCW     = clog2(RX_DEPTH) + 1;
    localparam int TCW     = clog2(TX_DEPTH) + 1;
    localparam int OVF_BIT = ovf_bit(DATA_W);

    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [RCW-1:0]    rx_count;
    logic [TCW-1:0]    tx_count;
    logic [DATA_W-1:0] rx_head, tx_head;
    logic              rd_en, wr_en;
    logic              rx_push, rx_pop, tx_push, launch;
    logic              ovf, ovf_set, ovf_clr;
    logic [DATA_W-1:0] rd_data;

    assign rd_en   = nicEN && !nicWrEn;
    assign wr_en   = nicEN && nicWrEn;
    assign net_ro  = !rx_full;
    assign rx_push = net_si && net_ro;
    assign rx_pop  = rd_en && (addr == ADDR_RXBUF) && !rx_empty;
    // Full test uses the pre-edge state, so a same-cycle launch never frees a slot
    assign tx_push = wr_en && (addr == ADDR_TXBUF) && !tx_full;
    assign ovf_set = wr_en && (addr == ADDR_TXBUF) && tx_full;
    assign ovf_clr = rd_en && (addr == ADDR_TXSTAT);
    assign launch  = !tx_empty && net_ri && (tx_head[VC_BIT] == net_polarity);

    nic_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
        .clk       (clk),
        .rst_n     (reset),
        .push      (rx_push),
        .push_data (net_di),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .head      (rx_head)
    );

    nic_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
        .clk       (clk),
        .rst_n     (reset),
        .push      (tx_push),
        .push_data (d_in),
        .pop       (launch),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .head      (tx_head)
    );

    // Read-data mux for the processor register map
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_RXBUF: begin
                if (!rx_empty) rd_data = rx_head;
            end
            ADDR_RXSTAT: begin
                rd_data[RCW:STAT_CNT_LSB] = rx_count;
                rd_data[STAT_NE_BIT]      = !rx_empty;
            end
            ADDR_TXSTAT: begin
                rd_data[OVF_BIT]          = ovf;
                rd_data[TCW:STAT_CNT_LSB] = tx_count;
                rd_data[STAT_FULL_BIT]    = tx_full;
            end
            default: rd_data = '0;
        endcase
    end

    // Registered read data; holds on writes and idle cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_data;
        end
    end

    // Sticky overflow flag; a same-cycle overflow beats the clear-on-read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // TX launch register: one flit per cycle when the router is ready and the VC phase matches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            net_so <= 1'b0;
            net_do <= '0;
        end else if (launch) begin
            net_so <= 1'b1;
            net_do <= tx_head;
        end else begin
            net_so <= 1'b0;
        end
    end

endmodule
